// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline stall/flush controller for mem wait states, mispredicts, load-use RAW and multi-cycle EX ops
module hazard_ctrl_unit #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4,
  parameter int FWD_EN  = 1,
  parameter int RA_W    = 5,
  parameter int PERF_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mispred,
  input  logic [RA_W-1:0]   i_ID_rs1_addr,
  input  logic              i_ID_rs1_used,
  input  logic [RA_W-1:0]   i_ID_rs2_addr,
  input  logic              i_ID_rs2_used,
  input  logic              i_EX_rd_wren,
  input  logic [RA_W-1:0]   i_EX_rd_addr,
  input  logic              i_EX_is_load,
  input  logic              i_EX_mc_start,
  input  logic              i_EX_mc_done,
  input  logic              i_MEM_valid,
  input  logic              i_MEM_is_load,
  input  logic              i_MEM_rd_wren,
  input  logic [RA_W-1:0]   i_MEM_rd_addr,
  output logic              o_pc_stall,
  output logic              o_IF_ID_stall,
  output logic              o_IF_ID_flush,
  output logic              o_ID_EX_stall,
  output logic              o_ID_EX_flush,
  output logic              o_EX_MEM_stall,
  output logic              o_EX_MEM_flush,
  output logic              o_MEM_WB_stall,
  output logic              o_MEM_WB_flush,
  output logic [1:0]        o_state,
  output logic [PERF_W-1:0] o_stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MC_BUSY = 2'd2} state_t;
  state_t st;
  logic [CNT_W-1:0] cnt;
  logic hit_ex, hit_mem, go_wait, mem_act, mp_act, go_mc, mc_act, raw_act, pc_stall;
  // hazard detection and priority resolution: mem wait > mispredict > multi-cycle > RAW
  always_comb begin
    hit_ex  = i_EX_rd_wren & (i_EX_rd_addr != '0) &
              ((i_ID_rs1_used & (i_EX_rd_addr == i_ID_rs1_addr)) | (i_ID_rs2_used & (i_EX_rd_addr == i_ID_rs2_addr)));
    hit_mem = i_MEM_rd_wren & (i_MEM_rd_addr != '0) &
              ((i_ID_rs1_used & (i_MEM_rd_addr == i_ID_rs1_addr)) | (i_ID_rs2_used & (i_MEM_rd_addr == i_ID_rs2_addr)));
    go_wait = (st == RUN) & i_MEM_valid & i_MEM_is_load & (MEM_LAT > 1);
    mem_act = go_wait | ((st == MEM_WAIT) & (cnt != '0));
    mp_act  = i_mispred & ~mem_act;
    go_mc   = (st == RUN) & i_EX_mc_start & ~i_EX_mc_done & ~mem_act & ~mp_act;
    mc_act  = go_mc | ((st == MC_BUSY) & ~i_EX_mc_done & ~mp_act);
    raw_act = (st == RUN) & ~mem_act & ~mp_act & ~mc_act &
              ((FWD_EN != 0) ? (hit_ex & i_EX_is_load) : (hit_ex | hit_mem));
    pc_stall = i_reset & (mem_act | mc_act | raw_act);
  end
  assign o_pc_stall     = pc_stall;
  assign o_IF_ID_stall  = pc_stall;
  assign o_IF_ID_flush  = i_reset & mp_act;
  assign o_ID_EX_stall  = i_reset & (mem_act | mc_act);
  assign o_ID_EX_flush  = i_reset & (mp_act | raw_act);
  assign o_EX_MEM_stall = i_reset & mem_act;
  assign o_EX_MEM_flush = i_reset & mc_act;
  assign o_MEM_WB_stall = 1'b0;
  assign o_MEM_WB_flush = i_reset & mem_act;
  assign o_state        = st;
  // FSM and wait-state counter; a load enters MEM_WAIT once and leaves on the cnt==0 release cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st  <= go_wait ? MEM_WAIT :
             ((st == MEM_WAIT) & (cnt == '0)) ? RUN :
             go_mc ? MC_BUSY :
             ((st == MC_BUSY) & i_EX_mc_done) ? RUN : st;
      cnt <= go_wait ? CNT_W'(MEM_LAT > 1 ? MEM_LAT - 2 : 0) :
             ((st == MEM_WAIT) & (cnt != '0)) ? cnt - 1'b1 : cnt;
    end
  end
  // saturating count of cycles in which the PC is held
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) o_stall_cnt <= '0;
    else          o_stall_cnt <= o_stall_cnt + PERF_W'(pc_stall & ~&o_stall_cnt);
  end
endmodule
